// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the multi-pattern serial sequence detector.
package seq_det_pkg;

   localparam int unsigned SEQ_W_DEF   = 8;
   localparam int unsigned NUM_PAT_DEF = 4;
   localparam int unsigned CNT_W_DEF   = 16;

   // Slot-index width for a given slot count; a single slot still gets one bit.
   function automatic int unsigned idx_w(input int unsigned num_pat);
      return (num_pat > 1) ? $clog2(num_pat) : 1;
   endfunction

   localparam int unsigned IDX_W = idx_w(NUM_PAT_DEF);

endpackage

// File: rtl/multi_pattern_seq_detector_if.sv
// Config, serial-data and match-report bundle of the sequence detector.
interface multi_pattern_seq_detector_if #(
   parameter int unsigned SEQ_W   = 8,
   parameter int unsigned NUM_PAT = 4,
   parameter int unsigned CNT_W   = 16,
   parameter int unsigned IDX_W   = seq_det_pkg::idx_w(NUM_PAT)
);
   logic                     cfg_we;
   logic [IDX_W-1:0]         cfg_idx;
   logic [SEQ_W-1:0]         cfg_pat;
   logic [SEQ_W-1:0]         cfg_mask;
   logic                     cfg_en;
   logic                     overlap;
   logic                     din_valid;
   logic                     din;
   logic                     cnt_clr;
   logic [NUM_PAT-1:0]       seen;
   logic                     seen_any;
   logic [NUM_PAT*CNT_W-1:0] match_cnt;

   modport master (
      output cfg_we, cfg_idx, cfg_pat, cfg_mask, cfg_en, overlap, din_valid, din, cnt_clr,
      input  seen, seen_any, match_cnt
   );

   modport slave (
      input  cfg_we, cfg_idx, cfg_pat, cfg_mask, cfg_en, overlap, din_valid, din, cnt_clr,
      output seen, seen_any, match_cnt
   );
endinterface

// File: rtl/seq_det_slot.sv
// One pattern slot: config registers, masked compare and (MATCH_COUNT_EN) saturating match counter.
module seq_det_slot #(
   parameter int unsigned SEQ_W = 8,
   parameter int unsigned CNT_W = 16
)(
   input  logic             clk,
   input  logic             resetn,
   input  logic             i_we,
   input  logic [SEQ_W-1:0] i_pat,
   input  logic [SEQ_W-1:0] i_mask,
   input  logic             i_en,
   input  logic [SEQ_W-1:0] i_hist,
   input  logic             i_eval,
   input  logic             i_cnt_clr,
   output logic             o_match_c,
   output logic [CNT_W-1:0] o_cnt
);
   typedef struct packed {
      logic [SEQ_W-1:0] pat;
      logic [SEQ_W-1:0] mask;
      logic             en;
   } slot_cfg_t;

   slot_cfg_t r_cfg;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_cfg <= '0;
      end else if (i_we) begin
         r_cfg.pat  <= i_pat;
         r_cfg.mask <= i_mask;
         r_cfg.en   <= i_en;
      end
   end

   // Compare uses the pre-write config, so a same-cycle write only affects later beats.
   assign o_match_c = i_eval && r_cfg.en && (((i_hist ^ r_cfg.pat) & r_cfg.mask) == '0);

`ifdef MATCH_COUNT_EN
   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!resetn || i_cnt_clr) begin
         r_cnt <= '0;
      end else if (o_match_c && (r_cnt != '1)) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_cnt = r_cnt;
`else
   logic w_unused_cnt_clr;
   assign w_unused_cnt_clr = i_cnt_clr;
   assign o_cnt            = '0;
`endif

endmodule

// File: rtl/multi_pattern_seq_detector.sv
// Serial bit-stream detector matching the last SEQ_W bits against NUM_PAT maskable patterns.
// Optional per-slot saturating match counters are built when MATCH_COUNT_EN is defined.
module multi_pattern_seq_detector
   import seq_det_pkg::*;
#(
   parameter int unsigned SEQ_W   = SEQ_W_DEF,
   parameter int unsigned NUM_PAT = NUM_PAT_DEF,
   parameter int unsigned CNT_W   = CNT_W_DEF
)(
   input  logic                        clk,
   input  logic                        resetn,
   multi_pattern_seq_detector_if.slave bus
);
   localparam int unsigned CFG_IDX_W = idx_w(NUM_PAT);
   localparam int unsigned FILL_W    = $clog2(SEQ_W + 1);

   logic [SEQ_W-1:0]         r_hist;
   logic [FILL_W-1:0]        r_fill;
   logic [NUM_PAT-1:0]       r_seen;
   logic                     r_seen_any;

   logic [SEQ_W-1:0]         w_new_hist;
   logic [FILL_W-1:0]        w_fill_inc;
   logic                     w_eval;
   logic [NUM_PAT-1:0]       w_match;
   logic [NUM_PAT*CNT_W-1:0] w_cnt;

   assign w_new_hist = {r_hist[SEQ_W-2:0], bus.din};
   assign w_fill_inc = (r_fill == FILL_W'(SEQ_W)) ? r_fill : r_fill + FILL_W'(1);
   assign w_eval     = bus.din_valid && (w_fill_inc == FILL_W'(SEQ_W));

   // Out-of-range cfg_idx equals no slot index, so such writes fall through.
   for (genvar gi = 0; gi < NUM_PAT; gi++) begin : g_slot
      seq_det_slot #(
         .SEQ_W (SEQ_W),
         .CNT_W (CNT_W)
      ) u_slot (
         .clk       (clk),
         .resetn    (resetn),
         .i_we      (bus.cfg_we && (bus.cfg_idx == CFG_IDX_W'(gi))),
         .i_pat     (bus.cfg_pat),
         .i_mask    (bus.cfg_mask),
         .i_en      (bus.cfg_en),
         .i_hist    (w_new_hist),
         .i_eval    (w_eval),
         .i_cnt_clr (bus.cnt_clr),
         .o_match_c (w_match[gi]),
         .o_cnt     (w_cnt[gi*CNT_W +: CNT_W])
      );
   end

   // In non-overlapping mode any match restarts the fill, blocking matches for SEQ_W beats.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_hist     <= '0;
         r_fill     <= '0;
         r_seen     <= '0;
         r_seen_any <= 1'b0;
      end else begin
         r_seen     <= w_match;
         r_seen_any <= |w_match;
         if (bus.din_valid) begin
            r_hist <= w_new_hist;
            r_fill <= (!bus.overlap && (|w_match)) ? '0 : w_fill_inc;
         end
      end
   end

   assign bus.seen      = r_seen;
   assign bus.seen_any  = r_seen_any;
   assign bus.match_cnt = w_cnt;

endmodule

// File: tb/tb_multi_pattern_seq_detector.sv
// Self-checking bench for multi_pattern_seq_detector: directed scenarios plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_multi_pattern_seq_detector;

   localparam int unsigned SEQ_W   = 8;
   localparam int unsigned NUM_PAT = 4;
   localparam int unsigned CNT_W   = 2;
   localparam int unsigned IDX_W   = 2;
   localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic resetn;

   always #5 clk = ~clk;

   multi_pattern_seq_detector_if #(.SEQ_W(SEQ_W), .NUM_PAT(NUM_PAT), .CNT_W(CNT_W)) bus ();
   multi_pattern_seq_detector_if #(.SEQ_W(SEQ_W), .NUM_PAT(3), .CNT_W(CNT_W)) bus2 ();

   multi_pattern_seq_detector #(.SEQ_W(SEQ_W), .NUM_PAT(NUM_PAT), .CNT_W(CNT_W)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   multi_pattern_seq_detector #(.SEQ_W(SEQ_W), .NUM_PAT(3), .CNT_W(CNT_W)) dut3 (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus2)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model state
   bit                       mq[$];
   int                       since;
   logic [SEQ_W-1:0]         m_pat  [NUM_PAT];
   logic [SEQ_W-1:0]         m_mask [NUM_PAT];
   bit                       m_en   [NUM_PAT];
   int                       m_cnt  [NUM_PAT];
   logic [NUM_PAT-1:0]       exp_seen;
   logic [NUM_PAT*CNT_W-1:0] exp_cnt;
   int                       hits   [NUM_PAT];

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Newest bit at index 0
   function automatic logic [SEQ_W-1:0] hist_now();
      logic [SEQ_W-1:0] h;
      for (int j = 0; j < SEQ_W; j++) h[j] = mq[mq.size() - 1 - j];
      return h;
   endfunction

   task automatic model_step();
      logic [SEQ_W-1:0] h;
      exp_seen = '0;
      if (!resetn) begin
         mq.delete();
         for (int j = 0; j < SEQ_W; j++) mq.push_back(1'b0);
         since = 0;
         for (int i = 0; i < NUM_PAT; i++) begin
            m_pat[i] = '0; m_mask[i] = '0; m_en[i] = 1'b0; m_cnt[i] = 0;
         end
      end else begin
         if (bus.din_valid) begin
            mq.push_back(bus.din);
            void'(mq.pop_front());
            h = hist_now();
            if (since < SEQ_W) since++;
            if (since == SEQ_W)
               for (int i = 0; i < NUM_PAT; i++)
                  if (m_en[i] && (((h ^ m_pat[i]) & m_mask[i]) == '0)) exp_seen[i] = 1'b1;
            if (!bus.overlap && (exp_seen != '0)) since = 0;
         end
`ifdef MATCH_COUNT_EN
         for (int i = 0; i < NUM_PAT; i++) begin
            if (bus.cnt_clr) m_cnt[i] = 0;
            else if (exp_seen[i] && (m_cnt[i] < int'(CNT_MAX))) m_cnt[i]++;
         end
`endif
         if (bus.cfg_we && (int'(bus.cfg_idx) < NUM_PAT)) begin
            m_pat[bus.cfg_idx]  = bus.cfg_pat;
            m_mask[bus.cfg_idx] = bus.cfg_mask;
            m_en[bus.cfg_idx]   = bus.cfg_en;
         end
      end
      for (int i = 0; i < NUM_PAT; i++) exp_cnt[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
      chk("seen", 64'(bus.seen), 64'(exp_seen));
      chk("seen_any", 64'(bus.seen_any), 64'(|exp_seen));
      chk("match_cnt", 64'(bus.match_cnt), 64'(exp_cnt));
      for (int i = 0; i < NUM_PAT; i++) hits[i] += int'(bus.seen[i]);
   endtask

   task automatic clear_hits();
      for (int i = 0; i < NUM_PAT; i++) hits[i] = 0;
   endtask

   task automatic beat(input logic b);
      bus.din_valid = 1'b1;
      bus.din       = b;
      tick();
      bus.din_valid = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] v);
      for (int k = 7; k >= 0; k--) beat(v[k]);
   endtask

   task automatic write_slot(input int idx, input logic [SEQ_W-1:0] pat,
                             input logic [SEQ_W-1:0] mask, input logic en);
      bus.cfg_we   = 1'b1;
      bus.cfg_idx  = IDX_W'(idx);
      bus.cfg_pat  = pat;
      bus.cfg_mask = mask;
      bus.cfg_en   = en;
      tick();
      bus.cfg_we   = 1'b0;
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      tick();
      tick();
      resetn = 1'b1;
      clear_hits();
   endtask

   logic [7:0] v;
   int         tot;

   initial begin
      resetn        = 1'b0;
      bus.cfg_we    = 1'b0; bus.cfg_idx = '0; bus.cfg_pat = '0; bus.cfg_mask = '0; bus.cfg_en = 1'b0;
      bus.overlap   = 1'b1; bus.din_valid = 1'b0; bus.din = 1'b0; bus.cnt_clr = 1'b0;
      bus2.cfg_we   = 1'b0; bus2.cfg_idx = '0; bus2.cfg_pat = '0; bus2.cfg_mask = '0; bus2.cfg_en = 1'b0;
      bus2.overlap  = 1'b1; bus2.din_valid = 1'b0; bus2.din = 1'b0; bus2.cnt_clr = 1'b0;
      clear_hits();

      do_reset();
      chk("rst_seen", 64'(bus.seen), 64'd0);
      chk("rst_cnt", 64'(bus.match_cnt), 64'd0);

      // 0xB2 on slot 0, overlapping
      write_slot(0, 8'hB2, 8'hFF, 1'b1);
      v = 8'hB2;
      for (int k = 7; k >= 1; k--) beat(v[k]);
      chk("b2_early", 64'(hits[0]), 64'd0);
      beat(v[0]);
      chk("b2_hit", 64'(bus.seen[0]), 64'd1);
      chk("b2_any", 64'(bus.seen_any), 64'd1);
      tick();
      chk("b2_one_cycle", 64'(bus.seen), 64'd0);

      // Alternating stream on slot 0x55, overlap then non-overlap
      do_reset();
      write_slot(1, 8'h55, 8'hFF, 1'b1);
      for (int k = 0; k < 12; k++) beat(k[0]);
      chk("alt_overlap", 64'(hits[1]), 64'd3);
      do_reset();
      bus.overlap = 1'b0;
      write_slot(1, 8'h55, 8'hFF, 1'b1);
      for (int k = 0; k < 12; k++) beat(k[0]);
      chk("alt_nonoverlap", 64'(hits[1]), 64'd1);
      for (int k = 12; k < 16; k++) beat(k[0]);
      chk("alt_nonoverlap16", 64'(hits[1]), 64'd2);

      // Nibble mask
      do_reset();
      write_slot(2, 8'h0F, 8'h0F, 1'b1);
      send_byte(8'hAF);
      send_byte(8'h3F);
      chk("mask_nibble", 64'(hits[2]), 64'd2);
      do_reset();
      write_slot(2, 8'h0F, 8'hFF, 1'b1);
      send_byte(8'hAF);
      send_byte(8'h3F);
      chk("mask_full", 64'(hits[2]), 64'd0);

      // Valid gaps inside the 0xB2 stream
      do_reset();
      bus.overlap = 1'b1;
      write_slot(0, 8'hB2, 8'hFF, 1'b1);
      for (int k = 7; k >= 0; k--) begin
         beat(v[k]);
         if (k != 0) repeat ($urandom_range(1, 3)) tick();
      end
      chk("gap_hit", 64'(bus.seen[0]), 64'd1);
      tick();
      chk("gap_count", 64'(hits[0]), 64'd1);

      // Config write coinciding with the completing beat
      do_reset();
      write_slot(0, 8'hB2, 8'hFF, 1'b1);
      for (int k = 7; k >= 1; k--) beat(v[k]);
      bus.cfg_we = 1'b1; bus.cfg_idx = 2'd0; bus.cfg_pat = 8'hB2; bus.cfg_mask = 8'hFF; bus.cfg_en = 1'b0;
      beat(v[0]);
      bus.cfg_we = 1'b0;
      chk("oldcfg_hit", 64'(bus.seen[0]), 64'd1);
      clear_hits();
      send_byte(8'hB2);
      chk("disabled_slot", 64'(hits[0]), 64'd0);

      // Counter saturation and clear-wins
      do_reset();
      write_slot(3, 8'h00, 8'h00, 1'b1);
      for (int k = 0; k < 12; k++) beat(1'($urandom));
      chk("cnt_hits", 64'(hits[3]), 64'd5);
`ifdef MATCH_COUNT_EN
      chk("cnt_sat", 64'(bus.match_cnt[3*CNT_W +: CNT_W]), 64'(CNT_MAX));
`else
      chk("cnt_tied", 64'(bus.match_cnt), 64'd0);
`endif
      bus.cnt_clr = 1'b1;
      beat(1'b1);
      bus.cnt_clr = 1'b0;
      chk("clr_seen", 64'(bus.seen[3]), 64'd1);
      chk("clr_wins", 64'(bus.match_cnt[3*CNT_W +: CNT_W]), 64'd0);

      // Reset mid-stream disables all slots
      beat(1'b0); beat(1'b1); beat(1'b1);
      resetn = 1'b0;
      tick();
      chk("midrst_seen", 64'(bus.seen), 64'd0);
      resetn = 1'b1;
      clear_hits();
      for (int k = 0; k < 10; k++) beat(1'($urandom));
      tot = 0;
      for (int i = 0; i < NUM_PAT; i++) tot += hits[i];
      chk("midrst_disabled", 64'(tot), 64'd0);

      // Out-of-range slot index on a 3-slot instance
      bus2.cfg_we = 1'b1; bus2.cfg_idx = 2'd3; bus2.cfg_pat = 8'h00; bus2.cfg_mask = 8'h00; bus2.cfg_en = 1'b1;
      tick();
      bus2.cfg_idx = 2'd2;
      tick();
      bus2.cfg_we = 1'b0;
      bus2.din_valid = 1'b1;
      for (int k = 0; k < 7; k++) begin
         bus2.din = 1'($urandom);
         tick();
         chk("idx_early", 64'(bus2.seen), 64'd0);
      end
      tick();
      bus2.din_valid = 1'b0;
      chk("idx_oob_ignored", 64'(bus2.seen), 64'b100);

      // Randomized traffic against the model
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         resetn        = ($urandom_range(0, 99) != 0);
         bus.din_valid = ($urandom_range(0, 3) != 0);
         bus.din       = 1'($urandom);
         bus.cfg_we    = ($urandom_range(0, 19) == 0);
         bus.cfg_idx   = IDX_W'($urandom);
         bus.cfg_pat   = SEQ_W'($urandom);
         bus.cfg_mask  = ($urandom_range(0, 1) != 0) ? SEQ_W'($urandom & $urandom & $urandom)
                                                     : SEQ_W'($urandom);
         bus.cfg_en    = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 15) == 0) bus.overlap = ~bus.overlap;
         bus.cnt_clr   = ($urandom_range(0, 49) == 0);
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
